// File: rtl/stream_mux4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux4_pkg
//  Brief    : Shared constants, FSM state type and winner-pick helpers for
//             the 4:1 packet stream multiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_mux4_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Round-robin pick: first requester scanning ptr, ptr+1, ptr+2, ptr+3.
  // The index wraps naturally in SEL_W bits.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CH-1:0]  req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Fixed-priority pick: lowest-numbered requester wins.
  function automatic logic [SEL_W-1:0] fp_pick(input logic [N_CH-1:0] req);
    logic [SEL_W-1:0] win;
    win = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        win = SEL_W'(k);
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux4_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb4
//  Brief    : Combinational 4-way winner pick from a request vector.
//             Round-robin from ptr_i by default; with
//             STREAM_MUX4_FIXED_PRIO_EN defined it becomes fixed priority
//             (lowest index wins) and the ptr_i port disappears.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb4
  import stream_mux4_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
`ifndef STREAM_MUX4_FIXED_PRIO_EN
  input  logic [SEL_W-1:0] ptr_i,
`endif
  output logic [SEL_W-1:0] win_o
);

`ifdef STREAM_MUX4_FIXED_PRIO_EN
  // Fixed priority: a busy low channel can starve the others.
  assign win_o = fp_pick(req_i);
`else
  // Rotating priority starting at the channel after the last packet owner.
  assign win_o = rr_pick(req_i, ptr_i);
`endif

endmodule
`default_nettype wire

// File: rtl/stream_mux4.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux4
//  Brief    : 4:1 valid/ready packet multiplexer. Locks onto one channel per
//             packet (round-robin arbitration), forwards beats through a
//             registered output stage and tags each beat with its source
//             channel on out_sel.
//             Build option: STREAM_MUX4_FIXED_PRIO_EN selects fixed-priority
//             arbitration instead of round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux4
  import stream_mux4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   w_win;

  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_last_q;
  logic [SEL_W-1:0]   out_sel_q;

  logic               w_load_en;
  logic               w_ready_grant;
  logic               w_accept;
  logic [DATA_W-1:0]  w_lane [N_CH];

  // Split the flat input bus into per-channel lanes.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign w_lane[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Output stage can take a beat when empty or draining this cycle.
  assign w_load_en = !out_valid_q || out_ready;
  // Ready is withheld while rst_n is low so no source sees a handshake
  // for a beat that the reset is about to drop.
  assign w_ready_grant = rst_n && (state_q == LOCK) && w_load_en;
  assign w_accept      = w_ready_grant && in_valid[grant_q];

`ifdef STREAM_MUX4_FIXED_PRIO_EN
  rr_arb4 u_arb (
    .req_i (in_valid),
    .win_o (w_win)
  );
`else
  logic [SEL_W-1:0] ptr_q, ptr_d;

  rr_arb4 u_arb (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .win_o (w_win)
  );

  // Round-robin pointer moves past a channel once its packet completes.
  always_comb begin
    ptr_d = ptr_q;
    if (w_accept && in_last[grant_q]) begin
      ptr_d = grant_q + SEL_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Next-state: arbitrate in IDLE, hold the grant in LOCK until last beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    in_ready = '0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = w_win;
          state_d = LOCK;
        end
      end
      LOCK: begin
        in_ready[grant_q] = w_ready_grant;
        if (w_accept && in_last[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and grant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Output register: load on accepted beat, otherwise drain on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= w_lane[grant_q];
      out_last_q  <= in_last[grant_q];
      out_sel_q   <= grant_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux4
//  Brief    : Self-checking bench for stream_mux4 (DATA_W = 8). Each table
//             row is driven on the falling edge; outputs are compared 1 ns
//             later, so registered outputs reflect the preceding rising edge
//             and in_ready reflects the current state and inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux4;

`ifdef STREAM_MUX4_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  stream_mux4 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        chk;
    logic [3:0]  iv;
    logic [31:0] id;
    logic [3:0]  il;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic [1:0]  os;
    logic [3:0]  ir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input logic r, input logic c, input logic [3:0] iv,
                             input logic [31:0] id, input logic [3:0] il,
                             input logic ordy, input logic ov, input logic [7:0] od,
                             input logic ol, input logic [1:0] os, input logic [3:0] ir);
    vec_t v;
    v.rst_n = r;  v.chk = c;   v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
    v.ov    = ov; v.od  = od;  v.ol = ol; v.os = os; v.ir = ir;
    return v;
  endfunction

  // Expected owner of the k-th packet in the all-channels contention run.
  function automatic logic [1:0] ch(input int k);
    return FP ? 2'd0 : 2'(k % 4);
  endfunction

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int n;
    bit got;

    // ---- reset with all inputs active ----
    tbl.push_back(V(0,0,4'hF,32'hFFFFFFFF,4'hF,1, 0,8'h00,0,2'd0,4'h0));
    tbl.push_back(V(0,1,4'hF,32'hFFFFFFFF,4'hF,1, 0,8'h00,0,2'd0,4'h0));
    // ---- single channel 2, three beats ----
    tbl.push_back(V(1,1,4'h4,32'h00110000,4'h0,1, 0,8'h00,0,2'd0,4'h0));
    tbl.push_back(V(1,1,4'h4,32'h00110000,4'h0,1, 0,8'h00,0,2'd0,4'h4));
    tbl.push_back(V(1,1,4'h4,32'h00220000,4'h0,1, 1,8'h11,0,2'd2,4'h4));
    tbl.push_back(V(1,1,4'h4,32'h00330000,4'h4,1, 1,8'h22,0,2'd2,4'h4));
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 1,8'h33,1,2'd2,4'h0));
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 0,8'h33,1,2'd2,4'h0));
    // ---- reset again so contention starts from ptr = 0 ----
    tbl.push_back(V(0,1,4'hF,32'hFFFFFFFF,4'hF,1, 0,8'h33,1,2'd2,4'h0));
    tbl.push_back(V(0,1,4'hF,32'hFFFFFFFF,4'hF,1, 0,8'h00,0,2'd0,4'h0));
    // ---- contention: all channels, 1-beat packets ----
    tbl.push_back(V(1,1,4'hF,32'hA3A2A1A0,4'hF,1, 0,8'h00,0,2'd0,4'h0));
    tbl.push_back(V(1,1,4'hF,32'hA3A2A1A0,4'hF,1, 0,8'h00,0,2'd0,4'b0001 << ch(0)));
    for (int j = 0; j < 4; j++) begin
      tbl.push_back(V(1,1,4'hF,32'hA3A2A1A0,4'hF,1, 1,8'hA0 + 8'(ch(j)),1,ch(j),4'h0));
      tbl.push_back(V(1,1,4'hF,32'hA3A2A1A0,4'hF,1, 0,8'hA0 + 8'(ch(j)),1,ch(j),
                      4'b0001 << ch(j+1)));
    end
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 1,8'hA0 + 8'(ch(4)),1,ch(4),4'h0));
    // ---- backpressure: channel 1, out_ready low 5 cycles mid-packet ----
    tbl.push_back(V(1,1,4'h2,32'h00005100,4'h0,1, 0,8'hA0,1,2'd0,4'h0));
    tbl.push_back(V(1,1,4'h2,32'h00005100,4'h0,1, 0,8'hA0,1,2'd0,4'h2));
    for (int j = 0; j < 5; j++)
      tbl.push_back(V(1,1,4'h2,32'h00005200,4'h0,0, 1,8'h51,0,2'd1,4'h0));
    tbl.push_back(V(1,1,4'h2,32'h00005200,4'h0,1, 1,8'h51,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h2,32'h00005300,4'h0,1, 1,8'h52,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h2,32'h00005400,4'h2,1, 1,8'h53,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 1,8'h54,1,2'd1,4'h0));
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 0,8'h54,1,2'd1,4'h0));
    // ---- grant hold: channel 1 stalls 3 cycles while channel 3 waits ----
    tbl.push_back(V(1,1,4'h2,32'hC3006100,4'h0,1, 0,8'h54,1,2'd1,4'h0));
    tbl.push_back(V(1,1,4'hA,32'hC3006100,4'h0,1, 0,8'h54,1,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h8,32'hC3006100,4'h0,1, 1,8'h61,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h8,32'hC3006100,4'h0,1, 0,8'h61,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h8,32'hC3006100,4'h0,1, 0,8'h61,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'hA,32'hC3006200,4'h2,1, 0,8'h61,0,2'd1,4'h2));
    tbl.push_back(V(1,1,4'h8,32'hC3006200,4'h0,1, 1,8'h62,1,2'd1,4'h0));
    tbl.push_back(V(1,1,4'h8,32'hC3000000,4'h8,1, 0,8'h62,1,2'd1,4'h8));
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 1,8'hC3,1,2'd3,4'h0));
    // ---- reset mid-packet: move ptr to 2, then reset after beat 2 of 4 ----
    tbl.push_back(V(1,1,4'h2,32'h00007100,4'h2,1, 0,8'hC3,1,2'd3,4'h0));
    tbl.push_back(V(1,1,4'h2,32'h00007100,4'h2,1, 0,8'hC3,1,2'd3,4'h2));
    tbl.push_back(V(1,1,4'h4,32'h00810000,4'h0,1, 1,8'h71,1,2'd1,4'h0));
    tbl.push_back(V(1,1,4'h4,32'h00810000,4'h0,1, 0,8'h71,1,2'd1,4'h4));
    tbl.push_back(V(1,1,4'h4,32'h00820000,4'h0,1, 1,8'h81,0,2'd2,4'h4));
    tbl.push_back(V(0,1,4'h4,32'h00830000,4'h0,1, 1,8'h82,0,2'd2,4'h0));
    tbl.push_back(V(1,1,4'hF,32'h94939291,4'hF,1, 0,8'h00,0,2'd0,4'h0));
    tbl.push_back(V(1,1,4'hF,32'h94939291,4'hF,1, 0,8'h00,0,2'd0,4'h1));
    tbl.push_back(V(1,1,4'h0,32'h00000000,4'h0,1, 1,8'h91,1,2'd0,4'h0));

    // ---- apply the table ----
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      rst_n     = tbl[r].rst_n;
      in_valid  = tbl[r].iv;
      in_data   = tbl[r].id;
      in_last   = tbl[r].il;
      out_ready = tbl[r].ordy;
      #1;
      if (tbl[r].chk) begin
        check("out_valid", r, 32'(out_valid), 32'(tbl[r].ov));
        check("out_data",  r, 32'(out_data),  32'(tbl[r].od));
        check("out_last",  r, 32'(out_last),  32'(tbl[r].ol));
        check("out_sel",   r, 32'(out_sel),   32'(tbl[r].os));
        check("in_ready",  r, 32'(in_ready),  32'(tbl[r].ir));
      end
    end

    // ---- request-to-output latency for a lone single-beat packet ----
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 4'b0001;
    in_data   = 32'h0000005A;
    in_last   = 4'b0001;
    out_ready = 1'b1;
    n   = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    check("latency_cycles", 0, 32'(n), 32'd2);
    check("latency_data",   0, 32'(out_data), 32'h5A);
    check("latency_sel",    0, 32'(out_sel), 32'd0);
    @(negedge clk);
    in_valid = 4'b0000;
    in_last  = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
